// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        hold,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  op;
  logic        sign1, sign2;
  logic [31:0] opnd;
  logic [63:0] work;
  logic [4:0]  count;

  logic        signed1, signed2, s1_in, s2_in, is_div;
  logic [31:0] mag1, mag2;
  logic        div_zero, div_ovf, fast;
  logic [31:0] fast_result;
  logic [32:0] mul_sum;
  logic [63:0] mul_step, div_step, prod;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;
  logic [31:0] fix_result;

  always_comb begin
    is_div   = func3[2];
    signed1  = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
    signed2  = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    s1_in    = signed1 & operand_1[31];
    s2_in    = signed2 & operand_2[31];
    mag1     = s1_in ? -operand_1 : operand_1;
    mag2     = s2_in ? -operand_2 : operand_2;
    div_zero = is_div && (operand_2 == 32'd0);
    div_ovf  = ((func3 == 3'b100) || (func3 == 3'b110)) &&
               (operand_1 == 32'h8000_0000) && (operand_2 == 32'hFFFF_FFFF);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_result = func3[1] ? operand_1 : 32'hFFFF_FFFF;
    else          fast_result = func3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One shift-add step on {acc, multiplier}; one restoring step on {rem, quo}.
  always_comb begin
    mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    mul_step = {mul_sum, work[31:1]};
    shifted  = {work[63:32], work[31]};
    ge       = shifted >= {1'b0, opnd};
    diff     = shifted[31:0] - opnd;
    div_step = {(ge ? diff : shifted[31:0]), work[30:0], ge};
  end

  always_comb begin
    prod = (sign1 ^ sign2) ? -work : work;
    if (!op[2])     fix_result = (op == 3'b000) ? prod[31:0] : prod[63:32];
    else if (op[1]) fix_result = sign1 ? -work[63:32] : work[63:32];
    else            fix_result = (sign1 ^ sign2) ? -work[31:0] : work[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        stall = start & ~flush;
        if (start) state_next = fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (count == 5'd0) state_next = S_FIX;
      end
      S_FIX: begin
        stall      = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!hold) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 32'd0;
      count  <= 5'd0;
      work   <= 64'd0;
      opnd   <= 32'd0;
      op     <= 3'd0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (start) begin
          op    <= func3;
          sign1 <= s1_in;
          sign2 <= s2_in;
          count <= 5'd31;
          if (fast) result <= fast_result;
          else begin
            work <= is_div ? {32'd0, mag1} : {32'd0, mag2};
            opnd <= is_div ? mag2 : mag1;
          end
        end
        S_CALC: begin
          work  <= op[2] ? div_step : mul_step;
          count <= count - 5'd1;
        end
        S_FIX:   result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule
